rx_msg_sequencer: RTL and testbench
===================================

RX_MSG_SEQUENCER -- requirements
Module: rx_msg_sequencer

Interface
REQ-001 SHALL have parameter ID1, default 16'd101, meaning message ID routed to buffer 1.
REQ-002 SHALL have parameter ID2, default 16'd102, meaning message ID routed to buffer 2.
REQ-003 SHALL have parameter SYNC, default 16'h1234, meaning required sync word.
REQ-004 SHALL have parameters LEN1 and LEN2, default 16'd32 each, meaning required ByteCount for ID1 and ID2.
REQ-005 SHALL have port Clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port Clear_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have ports SyncWord, MessageID, ByteCount and SequenceNumber, each input, 16, meaning header fields from the header demux, stable on the cycle MessageComplete is high.
REQ-008 SHALL have port MessageComplete, input, 1, meaning a one-cycle pulse marking the end of a received message.
REQ-009 SHALL have ports Msg1Start and Msg2Start, each output, 1, meaning a one-cycle pulse handing the filled buffer to its consumer.
REQ-010 SHALL have ports Msg1Done and Msg2Done, each input, 1, meaning a one-cycle pulse from the consumer that releases its buffer.
REQ-011 SHALL have ports Msg1Busy and Msg2Busy, each output, 1, meaning the buffer is owned by its consumer.
REQ-012 SHALL have ports AckReq (output, 1) and AckGrant (input, 1), meaning the acknowledge request to the transmitter and its acceptance.
REQ-013 SHALL have ports AckId (output, 16), AckSeq (output, 16) and AckStatus (output, 2), meaning the acknowledge payload, valid while AckReq is high.
REQ-014 SHALL have ports ErrCount (output, 8) and Overrun (output, 1), meaning the error count and a sticky event-loss flag.
REQ-015 SHALL have ports SeqGap (output, 1) and SeqErrCount (output, 8), meaning sequence-check status (see Configuration).

Function
REQ-016 SHALL capture the header fields into a one-deep event latch on the cycle MessageComplete is high, and set Pending.
REQ-017 SHALL, if MessageComplete is high while Pending is set, drop the new event and set Overrun until reset.
REQ-018 SHALL implement the FSM states IDLE, CHECK and ACK: IDLE goes to CHECK when Pending; CHECK goes to ACK after one cycle and clears Pending; ACK goes to IDLE on the cycle AckGrant is high.
REQ-019 SHALL, in CHECK, compute AckStatus in this priority order: 1 if SyncWord is not SYNC; 2 if the ID is unknown or ByteCount does not match LEN1/LEN2; 3 if the target buffer is busy; otherwise 0.
REQ-020 SHALL, on the CHECK-to-ACK transition with status 0, pulse Msg1Start or Msg2Start for exactly one cycle and set the matching Busy flag on the same edge.
REQ-021 SHALL clear MsgxBusy on the cycle after MsgxDone is high; Done while not Busy has no effect.
REQ-022 SHALL hold AckReq high through all of ACK, with AckId and AckSeq equal to the latched MessageID and SequenceNumber and held stable until AckGrant.
REQ-023 SHALL, if AckGrant is high outside ACK, ignore it.
REQ-024 SHALL increment ErrCount by one for each non-zero status, saturating at 255.
REQ-025 SHALL have latency from MessageComplete (cycle N) to Start/AckReq of cycle N+2 when IDLE.
REQ-026 SHALL accept a MessageComplete arriving during ACK into the latch and process it after returning to IDLE.

Reset
REQ-027 SHALL, while Clear_n is low, asynchronously force IDLE, Pending=0, all Start/Busy/AckReq=0, AckId/AckSeq/AckStatus=0, ErrCount=0, Overrun=0, SeqGap=0, SeqErrCount=0 and the expected sequence number to 0.
REQ-028 SHALL, on reset during ACK, drop the outstanding acknowledge without completing it.

Configuration
REQ-029 SHALL, with SEQ_CHECK_EN defined, compare each SequenceNumber against the expected value (the previous one plus 1, wrapping modulo 2^16, first expected 0); a mismatch sets SeqGap sticky and increments SeqErrCount (saturating at 255), dispatch is unaffected, and the expected value resyncs to the received value plus 1.
REQ-030 SHALL, without SEQ_CHECK_EN, tie SeqGap and SeqErrCount to 0 and omit the sequence logic.

Structure
REQ-031 SHALL place the FSM state enum, the status codes (OK, BAD_SYNC, BAD_FMT, BUSY) and the counter width in a shared package rx_msg_pkg.
REQ-032 SHALL use one sub-module, sat_counter (8-bit saturating incrementer), instantiated for ErrCount and SeqErrCount.

Verification
REQ-033 SHALL cover: ID 101, sync 16'h1234, count 32 -> Msg1Start at N+2, AckStatus 0, Msg1Busy=1; AckGrant -> IDLE.
REQ-034 SHALL cover: sync 16'h0000 -> AckStatus 1, no Start, ErrCount 1.
REQ-035 SHALL cover: two ID 102 messages without Msg2Done -> second AckStatus 3; after Msg2Done a third message -> status 0.
REQ-036 SHALL cover: a second MessageComplete while Pending -> Overrun=1 and only one AckReq issued.
REQ-037 SHALL cover: with SEQ_CHECK_EN, sequence 0,1,3 -> SeqGap=1 and SeqErrCount 1; then 4 -> no further increment.
REQ-038 SHALL cover: 300 bad messages -> ErrCount 255; Clear_n low mid-ACK -> AckReq drops immediately and all outputs return to 0.

Source files
------------

// File: rtl/rx_msg_pkg.sv
// Shared types for the receive message sequencer: FSM states, acknowledge
// status codes and the width of the error/sequence counters.
package rx_msg_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ACK   = 2'd2
    } seqState_t;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        BAD_SYNC = 2'd1,
        BAD_FMT  = 2'd2,
        BUSY     = 2'd3
    } ackStatus_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating incrementer: counts single-cycle increment requests and sticks
// at all-ones instead of wrapping.
module sat_counter
    import rx_msg_pkg::*;
(
    input  logic               Clock,
    input  logic               Clear_n,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    // Count up on each request until the counter is full, then hold.
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            count <= '0;
        end else if (inc && (count != {COUNT_W{1'b1}})) begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/rx_msg_sequencer.sv
// Receive message sequencer: latches the header of each completed message,
// validates it, hands good messages to one of two buffer consumers and
// requests an acknowledge carrying the verdict.
// Optional feature: define SEQ_CHECK_EN to enable sequence-number gap checking;
// without it SeqGap and SeqErrCount are tied to zero.
module rx_msg_sequencer
    import rx_msg_pkg::*;
#(
    parameter logic [15:0] ID1  = 16'd101,
    parameter logic [15:0] ID2  = 16'd102,
    parameter logic [15:0] SYNC = 16'h1234,
    parameter logic [15:0] LEN1 = 16'd32,
    parameter logic [15:0] LEN2 = 16'd32
) (
    input  logic               Clock,
    input  logic               Clear_n,
    input  logic [15:0]        SyncWord,
    input  logic [15:0]        MessageID,
    input  logic [15:0]        ByteCount,
    input  logic [15:0]        SequenceNumber,
    input  logic               MessageComplete,
    output logic               Msg1Start,
    output logic               Msg2Start,
    input  logic               Msg1Done,
    input  logic               Msg2Done,
    output logic               Msg1Busy,
    output logic               Msg2Busy,
    output logic               AckReq,
    input  logic               AckGrant,
    output logic [15:0]        AckId,
    output logic [15:0]        AckSeq,
    output logic [1:0]         AckStatus,
    output logic [COUNT_W-1:0] ErrCount,
    output logic               Overrun,
    output logic               SeqGap,
    output logic [COUNT_W-1:0] SeqErrCount
);

    seqState_t   state;
    seqState_t   nextState;
    ackStatus_t  checkStatus;

    logic        pending;
    logic [15:0] latSync;
    logic [15:0] latId;
    logic [15:0] latCount;
    logic [15:0] latSeq;
    logic        errInc;

    // One-deep event latch; a completion that arrives while one is still
    // pending is dropped and remembered as an overrun.
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            pending  <= 1'b0;
            latSync  <= '0;
            latId    <= '0;
            latCount <= '0;
            latSeq   <= '0;
            Overrun  <= 1'b0;
        end else begin
            if (MessageComplete && !pending) begin
                pending  <= 1'b1;
                latSync  <= SyncWord;
                latId    <= MessageID;
                latCount <= ByteCount;
                latSeq   <= SequenceNumber;
            end else if (MessageComplete && pending) begin
                Overrun <= 1'b1;
            end
            if (state == CHECK) begin
                pending <= 1'b0;
            end
        end
    end

    // Header verdict in priority order: sync, then format, then buffer ownership.
    always_comb begin
        checkStatus = OK;
        if (latSync != SYNC) begin
            checkStatus = BAD_SYNC;
        end else if (latId == ID1) begin
            if (latCount != LEN1) begin
                checkStatus = BAD_FMT;
            end else if (Msg1Busy) begin
                checkStatus = BUSY;
            end
        end else if (latId == ID2) begin
            if (latCount != LEN2) begin
                checkStatus = BAD_FMT;
            end else if (Msg2Busy) begin
                checkStatus = BUSY;
            end
        end else begin
            checkStatus = BAD_FMT;
        end
    end

    // State register.
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state; a completion seen in IDLE starts checking on the capture
    // edge so Start/AckReq appear two cycles after MessageComplete.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (pending || MessageComplete) nextState = CHECK;
            CHECK:   nextState = ACK;
            ACK:     if (AckGrant) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign AckReq = (state == ACK);

    // Dispatch, buffer ownership and acknowledge payload, all loaded on the
    // CHECK-to-ACK edge so the payload stays fixed for the whole handshake.
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            Msg1Start <= 1'b0;
            Msg2Start <= 1'b0;
            Msg1Busy  <= 1'b0;
            Msg2Busy  <= 1'b0;
            AckId     <= '0;
            AckSeq    <= '0;
            AckStatus <= '0;
        end else begin
            Msg1Start <= 1'b0;
            Msg2Start <= 1'b0;
            if (Msg1Done) begin
                Msg1Busy <= 1'b0;
            end
            if (Msg2Done) begin
                Msg2Busy <= 1'b0;
            end
            if (state == CHECK) begin
                AckId     <= latId;
                AckSeq    <= latSeq;
                AckStatus <= checkStatus;
                if (checkStatus == OK) begin
                    if (latId == ID1) begin
                        Msg1Start <= 1'b1;
                        Msg1Busy  <= 1'b1;
                    end else begin
                        Msg2Start <= 1'b1;
                        Msg2Busy  <= 1'b1;
                    end
                end
            end
        end
    end

    assign errInc = (state == CHECK) && (checkStatus != OK);

    sat_counter uErrCount (
        .Clock   (Clock),
        .Clear_n (Clear_n),
        .inc     (errInc),
        .count   (ErrCount)
    );

`ifdef SEQ_CHECK_EN
    logic [15:0] expSeq;
    logic        seqMiss;

    assign seqMiss = (state == CHECK) && (latSeq != expSeq);

    // Track the expected sequence number, resyncing to whatever arrived.
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            expSeq <= '0;
            SeqGap <= 1'b0;
        end else if (state == CHECK) begin
            expSeq <= latSeq + 16'd1;
            if (seqMiss) begin
                SeqGap <= 1'b1;
            end
        end
    end

    sat_counter uSeqErrCount (
        .Clock   (Clock),
        .Clear_n (Clear_n),
        .inc     (seqMiss),
        .count   (SeqErrCount)
    );
`else
    assign SeqGap      = 1'b0;
    assign SeqErrCount = '0;
`endif

endmodule

// File: tb/tb_rx_msg_sequencer.sv
// Self-checking bench for rx_msg_sequencer: a table of single messages with
// hand-computed verdicts, then directed sequences for overrun, back-to-back
// events, counter saturation, reset during acknowledge and sequence checking.
module tb_rx_msg_sequencer;

    logic        Clock = 1'b0;
    logic        Clear_n = 1'b0;
    logic [15:0] SyncWord = '0;
    logic [15:0] MessageID = '0;
    logic [15:0] ByteCount = '0;
    logic [15:0] SequenceNumber = '0;
    logic        MessageComplete = 1'b0;
    logic        Msg1Start, Msg2Start;
    logic        Msg1Done = 1'b0;
    logic        Msg2Done = 1'b0;
    logic        Msg1Busy, Msg2Busy;
    logic        AckReq;
    logic        AckGrant = 1'b0;
    logic [15:0] AckId, AckSeq;
    logic [1:0]  AckStatus;
    logic [7:0]  ErrCount;
    logic        Overrun;
    logic        SeqGap;
    logic [7:0]  SeqErrCount;

    int compared = 0;
    int mismatched = 0;

    int  errExp = 0;
    bit  busy1Exp = 1'b0;
    bit  busy2Exp = 1'b0;

    typedef struct {
        logic [15:0] sync;
        logic [15:0] id;
        logic [15:0] cnt;
        logic [15:0] seq;
        logic [1:0]  doneMask;
        logic [1:0]  expStatus;
        logic        expStart1;
        logic        expStart2;
    } vector_t;

    vector_t vecs[9];

    rx_msg_sequencer dut (
        .Clock           (Clock),
        .Clear_n         (Clear_n),
        .SyncWord        (SyncWord),
        .MessageID       (MessageID),
        .ByteCount       (ByteCount),
        .SequenceNumber  (SequenceNumber),
        .MessageComplete (MessageComplete),
        .Msg1Start       (Msg1Start),
        .Msg2Start       (Msg2Start),
        .Msg1Done        (Msg1Done),
        .Msg2Done        (Msg2Done),
        .Msg1Busy        (Msg1Busy),
        .Msg2Busy        (Msg2Busy),
        .AckReq          (AckReq),
        .AckGrant        (AckGrant),
        .AckId           (AckId),
        .AckSeq          (AckSeq),
        .AckStatus       (AckStatus),
        .ErrCount        (ErrCount),
        .Overrun         (Overrun),
        .SeqGap          (SeqGap),
        .SeqErrCount     (SeqErrCount)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 Clock = ~Clock;

    // Hard stop in case something hangs beyond every bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] sync, input logic [15:0] id,
                                 input logic [15:0] cnt, input logic [15:0] seq);
        SyncWord        = sync;
        MessageID       = id;
        ByteCount       = cnt;
        SequenceNumber  = seq;
        MessageComplete = 1'b1;
    endtask

    task automatic bumpErr();
        if (errExp < 255) errExp++;
    endtask

    task automatic waitAck(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (AckReq) break;
            tick();
        end
        checkOutput("ackReqTimeout", {31'd0, AckReq}, 32'd1);
    endtask

    task automatic pulseDone(input logic [1:0] mask);
        Msg1Done = mask[0];
        Msg2Done = mask[1];
        tick();
        Msg1Done = 1'b0;
        Msg2Done = 1'b0;
        if (mask[0]) busy1Exp = 1'b0;
        if (mask[1]) busy2Exp = 1'b0;
        checkOutput("busy1AfterDone", {31'd0, Msg1Busy}, {31'd0, busy1Exp});
        checkOutput("busy2AfterDone", {31'd0, Msg2Busy}, {31'd0, busy2Exp});
    endtask

    // One full message: completion at cycle N, results at N+2, held at N+3, then granted.
    task automatic sendMsg(input vector_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        applyStimulus(v.sync, v.id, v.cnt, v.seq);
        tick();
        MessageComplete = 1'b0;
        checkOutput({tag, ".ackReqN1"}, {31'd0, AckReq}, 32'd0);
        tick();
        if (v.expStatus != 2'd0) bumpErr();
        if (v.expStart1) busy1Exp = 1'b1;
        if (v.expStart2) busy2Exp = 1'b1;
        checkOutput({tag, ".ackReq"},    {31'd0, AckReq},    32'd1);
        checkOutput({tag, ".ackStatus"}, {30'd0, AckStatus}, {30'd0, v.expStatus});
        checkOutput({tag, ".ackId"},     {16'd0, AckId},     {16'd0, v.id});
        checkOutput({tag, ".ackSeq"},    {16'd0, AckSeq},    {16'd0, v.seq});
        checkOutput({tag, ".start1"},    {31'd0, Msg1Start}, {31'd0, v.expStart1});
        checkOutput({tag, ".start2"},    {31'd0, Msg2Start}, {31'd0, v.expStart2});
        checkOutput({tag, ".busy1"},     {31'd0, Msg1Busy},  {31'd0, busy1Exp});
        checkOutput({tag, ".busy2"},     {31'd0, Msg2Busy},  {31'd0, busy2Exp});
        tick();
        checkOutput({tag, ".start1Gone"}, {31'd0, Msg1Start}, 32'd0);
        checkOutput({tag, ".start2Gone"}, {31'd0, Msg2Start}, 32'd0);
        checkOutput({tag, ".ackHeld"},    {31'd0, AckReq},    32'd1);
        checkOutput({tag, ".ackIdHeld"},  {16'd0, AckId},     {16'd0, v.id});
        AckGrant = 1'b1;
        tick();
        AckGrant = 1'b0;
        checkOutput({tag, ".ackDropped"}, {31'd0, AckReq},   32'd0);
        checkOutput({tag, ".errCount"},   {24'd0, ErrCount}, errExp);
    endtask

    initial begin
        vector_t v;

        // sync, id, count, seq, doneBefore, status, start1, start2
        vecs[0] = '{16'h1234, 16'd101, 16'd32, 16'd0, 2'b00, 2'd0, 1'b1, 1'b0};
        vecs[1] = '{16'h0000, 16'd101, 16'd32, 16'd1, 2'b00, 2'd1, 1'b0, 1'b0};
        vecs[2] = '{16'h1234, 16'd102, 16'd32, 16'd2, 2'b00, 2'd0, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'd102, 16'd32, 16'd3, 2'b00, 2'd3, 1'b0, 1'b0};
        vecs[4] = '{16'h1234, 16'd103, 16'd32, 16'd4, 2'b00, 2'd2, 1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'd101, 16'd31, 16'd5, 2'b00, 2'd2, 1'b0, 1'b0};
        vecs[6] = '{16'hABCD, 16'd999, 16'd7,  16'd6, 2'b00, 2'd1, 1'b0, 1'b0};
        vecs[7] = '{16'h1234, 16'd102, 16'd32, 16'd7, 2'b10, 2'd0, 1'b0, 1'b1};
        vecs[8] = '{16'h1234, 16'd101, 16'd32, 16'd8, 2'b01, 2'd0, 1'b1, 1'b0};

        // Reset state.
        tick();
        tick();
        checkOutput("rstAckReq",   {31'd0, AckReq},    32'd0);
        checkOutput("rstBusy1",    {31'd0, Msg1Busy},  32'd0);
        checkOutput("rstErrCount", {24'd0, ErrCount},  32'd0);
        checkOutput("rstOverrun",  {31'd0, Overrun},   32'd0);
        checkOutput("rstAckId",    {16'd0, AckId},     32'd0);
        Clear_n = 1'b1;
        tick();

        // Table of single messages.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].doneMask != 2'b00) pulseDone(vecs[i].doneMask);
            sendMsg(vecs[i], i);
        end
        checkOutput("noOverrunYet", {31'd0, Overrun}, 32'd0);

        // Second completion while the first is still pending is dropped.
        applyStimulus(16'h0000, 16'd101, 16'd32, 16'd9);
        tick();
        applyStimulus(16'h1234, 16'd102, 16'd32, 16'd77);
        tick();
        MessageComplete = 1'b0;
        bumpErr();
        checkOutput("ovrAckReq",  {31'd0, AckReq},    32'd1);
        checkOutput("ovrAckId",   {16'd0, AckId},     32'd101);
        checkOutput("ovrStatus",  {30'd0, AckStatus}, 32'd1);
        checkOutput("ovrOverrun", {31'd0, Overrun},   32'd1);
        AckGrant = 1'b1;
        tick();
        AckGrant = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("ovrSingleAck", {31'd0, AckReq},   32'd0);
        checkOutput("ovrErrCount",  {24'd0, ErrCount}, errExp);

        // Completion during ACK is queued and handled after the grant.
        applyStimulus(16'h0000, 16'd101, 16'd32, 16'd10);
        tick();
        MessageComplete = 1'b0;
        tick();
        checkOutput("queueFirstAck", {31'd0, AckReq}, 32'd1);
        applyStimulus(16'h1234, 16'h0055, 16'd32, 16'd11);
        tick();
        MessageComplete = 1'b0;
        checkOutput("queueIdHeld", {16'd0, AckId}, 32'd101);
        AckGrant = 1'b1;
        tick();
        AckGrant = 1'b0;
        checkOutput("queueGap", {31'd0, AckReq}, 32'd0);
        waitAck(10);
        checkOutput("queueSecondId",     {16'd0, AckId},     32'h55);
        checkOutput("queueSecondStatus", {30'd0, AckStatus}, 32'd2);
        AckGrant = 1'b1;
        tick();
        AckGrant = 1'b0;
        bumpErr();
        bumpErr();
        checkOutput("queueErrCount", {24'd0, ErrCount}, errExp);

        // A grant outside ACK must not cut a later acknowledge short.
        pulseDone(2'b11);
        AckGrant = 1'b1;
        tick();
        applyStimulus(16'h1234, 16'd101, 16'd32, 16'd12);
        tick();
        MessageComplete = 1'b0;
        AckGrant = 1'b0;
        tick();
        checkOutput("strayGrantAck",    {31'd0, AckReq},    32'd1);
        checkOutput("strayGrantStart1", {31'd0, Msg1Start}, 32'd1);
        tick();
        checkOutput("strayGrantHeld",   {31'd0, AckReq},    32'd1);
        AckGrant = 1'b1;
        tick();
        AckGrant = 1'b0;
        busy1Exp = 1'b1;
        checkOutput("seqGapClean", {31'd0, SeqGap}, 32'd0);

        // Saturate the error counter with bad-sync messages.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(16'h0000, 16'd101, 16'd32, 16'(13 + i));
            tick();
            MessageComplete = 1'b0;
            waitAck(8);
            AckGrant = 1'b1;
            tick();
            AckGrant = 1'b0;
            bumpErr();
        end
        checkOutput("errSaturated", {24'd0, ErrCount}, 32'd255);

        // Reset in the middle of an acknowledge.
        applyStimulus(16'h0000, 16'd101, 16'd32, 16'd500);
        tick();
        MessageComplete = 1'b0;
        tick();
        checkOutput("preResetAck", {31'd0, AckReq}, 32'd1);
        Clear_n = 1'b0;
        #1;
        checkOutput("resetAckReq",   {31'd0, AckReq},      32'd0);
        checkOutput("resetBusy1",    {31'd0, Msg1Busy},    32'd0);
        checkOutput("resetBusy2",    {31'd0, Msg2Busy},    32'd0);
        checkOutput("resetStart1",   {31'd0, Msg1Start},   32'd0);
        checkOutput("resetAckId",    {16'd0, AckId},       32'd0);
        checkOutput("resetAckSeq",   {16'd0, AckSeq},      32'd0);
        checkOutput("resetStatus",   {30'd0, AckStatus},   32'd0);
        checkOutput("resetErrCount", {24'd0, ErrCount},    32'd0);
        checkOutput("resetOverrun",  {31'd0, Overrun},     32'd0);
        checkOutput("resetSeqGap",   {31'd0, SeqGap},      32'd0);
        checkOutput("resetSeqErr",   {24'd0, SeqErrCount}, 32'd0);
        errExp = 0;
        busy1Exp = 1'b0;
        busy2Exp = 1'b0;
        tick();
        Clear_n = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("droppedAck", {31'd0, AckReq}, 32'd0);

        // Sequence numbers 0,1,3,4 using an unknown ID so buffers stay free.
        v = '{16'h1234, 16'h0200, 16'd32, 16'd0, 2'b00, 2'd2, 1'b0, 1'b0};
        sendMsg(v, 100);
        v.seq = 16'd1;
        sendMsg(v, 101);
        checkOutput("seqNoGap", {31'd0, SeqGap}, 32'd0);
        v.seq = 16'd3;
        sendMsg(v, 102);
`ifdef SEQ_CHECK_EN
        checkOutput("seqGapSet",   {31'd0, SeqGap},      32'd1);
        checkOutput("seqErrOne",   {24'd0, SeqErrCount}, 32'd1);
`else
        checkOutput("seqGapTied",  {31'd0, SeqGap},      32'd0);
        checkOutput("seqErrTied",  {24'd0, SeqErrCount}, 32'd0);
`endif
        v.seq = 16'd4;
        sendMsg(v, 103);
`ifdef SEQ_CHECK_EN
        checkOutput("seqGapSticky", {31'd0, SeqGap},      32'd1);
        checkOutput("seqErrStill",  {24'd0, SeqErrCount}, 32'd1);
`else
        checkOutput("seqGapTied2",  {31'd0, SeqGap},      32'd0);
        checkOutput("seqErrTied2",  {24'd0, SeqErrCount}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
